// File: rtl/muxn_scan.sv
// muxn_scan: N-way W-bit registered mux with valid/ready output and round-robin channel scan.
//   Optional feature: define MUXN_PARITY_EN to add parity_out (even parity of the captured sample).
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset
//     data_in    in   N*W packed channels, channel k at [k*W +: W]
//     sel_in     in   manual channel select (scan_en=0)
//     scan_en    in   1 = internal scan pointer selects the channel
//     in_valid   in   source presents a sample
//     in_ready   out  stage can accept (!out_valid || out_ready)
//     data_out   out  registered selected data
//     ch_out     out  channel index that produced data_out
//     out_valid  out  data_out/ch_out hold a sample
//     out_ready  in   consumer accepts
//     sel_err    out  sticky: sample accepted with out-of-range manual select
//     parity_out out  (MUXN_PARITY_EN only) registered XOR-reduce of the captured data
module muxn_scan #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  data_in,
    input  logic [SELW-1:0] sel_in,
    input  logic            scan_en,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    data_out,
    output logic [SELW-1:0] ch_out,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef MUXN_PARITY_EN
    output logic            parity_out,
`endif
    output logic            sel_err
);
    localparam int DCW = $clog2(DWELL) + 1;
    localparam logic [DCW-1:0]  DW_LAST  = DCW'(DWELL - 1);
    localparam logic [SELW-1:0] PTR_LAST = SELW'(N - 1);

    logic [W-1:0]    data_q, data_d, sel_data;
    logic [SELW-1:0] ch_q, ch_d, ptr_q, ptr_d, esel;
    logic [DCW-1:0]  dwell_q, dwell_d;
    logic            valid_q, valid_d, err_q, err_d;
    logic            in_range, accept, dwell_wrap;
`ifdef MUXN_PARITY_EN
    logic            parity_q, parity_d;
`endif

    always_comb begin
        esel       = scan_en ? ptr_q : sel_in;
        // The scan pointer never exceeds N-1, so only manual selects can be out of range.
        in_range   = esel <= PTR_LAST;
        sel_data   = in_range ? data_in[esel*W +: W] : '0;
        in_ready   = !valid_q || out_ready;
        accept     = in_valid && in_ready;
        data_d     = accept ? sel_data : data_q;
        ch_d       = accept ? esel : ch_q;
        valid_d    = accept || (valid_q && !out_ready);
        err_d      = err_q || (accept && !in_range);
        dwell_wrap = dwell_q == DW_LAST;
        // Leaving scan mode clears the scan state, so re-entry starts at channel 0 with a fresh dwell.
        dwell_d    = !scan_en ? '0 : !accept ? dwell_q : dwell_wrap ? '0 : dwell_q + 1'b1;
        ptr_d      = !scan_en ? '0 : !(accept && dwell_wrap) ? ptr_q :
                     (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
`ifdef MUXN_PARITY_EN
        parity_d   = accept ? ^sel_data : parity_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ptr_q    <= '0;
            dwell_q  <= '0;
`ifdef MUXN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            data_q   <= data_d;
            ch_q     <= ch_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
            dwell_q  <= dwell_d;
`ifdef MUXN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign ch_out     = ch_q;
    assign out_valid  = valid_q;
    assign sel_err    = err_q;
`ifdef MUXN_PARITY_EN
    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_muxn_scan.sv
// tb_muxn_scan: directed scoreboard bench for muxn_scan (N=4 DWELL=2 instance plus an N=3 instance).
module tb_muxn_scan;
    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
    } exp_t;

    logic        clk;
    logic        reset, scan_en, in_valid, out_ready, in_ready, out_valid, sel_err;
    logic [31:0] data_in;
    logic [1:0]  sel_in, ch_out;
    logic [7:0]  data_out;
    logic        rst3, v3, in_ready3, out_valid3, sel_err3;
    logic [1:0]  sel3, ch_out3;
    logic [7:0]  data_out3;
`ifdef MUXN_PARITY_EN
    logic        parity_out, parity_out3;
`endif

    int   checks = 0;
    int   errors = 0;
    logic m_ov   = 1'b0;
    exp_t q[$];
    logic [7:0] dv [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    muxn_scan #(.W(8), .N(4), .SELW(2), .DWELL(2)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .sel_in(sel_in), .scan_en(scan_en),
        .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .ch_out(ch_out),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUXN_PARITY_EN
        .parity_out(parity_out),
`endif
        .sel_err(sel_err)
    );

    muxn_scan #(.W(8), .N(3), .SELW(2), .DWELL(2)) u_dut3 (
        .clk(clk), .reset(rst3), .data_in(data_in[23:0]), .sel_in(sel3), .scan_en(1'b0),
        .in_valid(v3), .in_ready(in_ready3), .data_out(data_out3), .ch_out(ch_out3),
        .out_valid(out_valid3), .out_ready(1'b1),
`ifdef MUXN_PARITY_EN
        .parity_out(parity_out3),
`endif
        .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus at a negedge; scoreboard pushes on accept and pops on drain.
    task automatic step(input logic v, input logic rdy, input logic [1:0] ch);
        logic exp_rdy, acc;
        exp_t e;
        in_valid  = v;
        out_ready = rdy;
        exp_rdy   = !m_ov || rdy;
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        acc = v && exp_rdy;
        if (m_ov && rdy && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            e.d = dv[ch];
            e.c = ch;
            q.push_back(e);
        end
        m_ov = acc || (m_ov && !rdy);
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        if (m_ov) begin
            if (q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
            else begin
                chk("data_out", {24'b0, data_out}, {24'b0, q[0].d});
                chk("ch_out", {30'b0, ch_out}, {30'b0, q[0].c});
            end
        end
    endtask

    initial begin
        reset = 1'b1; scan_en = 1'b0; sel_in = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
        data_in = 32'hD4C3B2A1;
        rst3 = 1'b1; sel3 = 2'd0; v3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", {24'b0, data_out}, 32'd0);
        chk("rst_ch", {30'b0, ch_out}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_err", {31'b0, sel_err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rdy_after_rst", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // Manual select, then backpressure with no loss or duplication
        sel_in = 2'd2;
        step(1, 1, 2);
        chk("man_err", {31'b0, sel_err}, 32'd0);
        sel_in = 2'd0;
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        sel_in = 2'd1;
        step(1, 1, 1);
`ifdef MUXN_PARITY_EN
        sel_in = 2'd0;
        step(1, 1, 0);
        chk("parity_a1", {31'b0, parity_out}, 32'd1);
        sel_in = 2'd2;
        step(1, 1, 2);
        chk("parity_c3", {31'b0, parity_out}, 32'd0);
`endif
        step(0, 1, 0);

        // Scan with wrap; sel_in must be ignored
        scan_en = 1'b1;
        sel_in  = 2'd3;
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 1); step(1, 1, 1); step(1, 1, 2);
        step(1, 1, 2); step(1, 1, 3); step(1, 1, 3); step(1, 1, 0); step(1, 1, 0);
        // Stall mid-dwell: pointer and dwell must hold
        step(1, 1, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 1);
        step(1, 1, 2);
        // Restart via scan_en toggle, with a backpressured cycle in between
        scan_en = 1'b0;
        step(0, 1, 0);
        scan_en = 1'b1;
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 1);

        // Reset mid-stream with a pending output and an accept offered
        scan_en = 1'b0;
        sel_in  = 2'd3;
        step(1, 0, 3);
        reset = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'b0, data_out}, 32'd0);
        chk("mid_rst_ch", {30'b0, ch_out}, 32'd0);
`ifdef MUXN_PARITY_EN
        chk("mid_rst_parity", {31'b0, parity_out}, 32'd0);
`endif
        q.delete();
        m_ov = 1'b0;
        reset = 1'b0;
        scan_en = 1'b1;
        step(1, 1, 0);
        step(0, 1, 0);

        // Out-of-range manual select on the N=3 instance
        rst3 = 1'b0;
        sel3 = 2'd3;
        v3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("oor_data", {24'b0, data_out3}, 32'd0);
        chk("oor_ch", {30'b0, ch_out3}, 32'd3);
        chk("oor_valid", {31'b0, out_valid3}, 32'd1);
        chk("oor_err", {31'b0, sel_err3}, 32'd1);
`ifdef MUXN_PARITY_EN
        chk("oor_parity", {31'b0, parity_out3}, 32'd0);
`endif
        sel3 = 2'd1;
        @(posedge clk);
        @(negedge clk);
        chk("n3_data", {24'b0, data_out3}, 32'hB2);
        chk("err_sticky", {31'b0, sel_err3}, 32'd1);
        v3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("err_sticky_idle", {31'b0, sel_err3}, 32'd1);
        chk("n3_drained", {31'b0, out_valid3}, 32'd0);
        rst3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("err_cleared", {31'b0, sel_err3}, 32'd0);
        rst3 = 1'b0;
        sel3 = 2'd2;
        v3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("n3_top_ch", {24'b0, data_out3}, 32'hC3);
        chk("n3_no_err", {31'b0, sel_err3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
